// File: rtl/opl3_pkg.sv
// Types shared by the host bus master and its users: request payload,
// operation encoding and the bus sequencer state encoding.
package opl3_pkg;

    localparam int REG_FILE_DATA_WIDTH = 8;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } host_bus_op_t;

    typedef struct packed {
        host_bus_op_t                   op;
        logic                           bank_num;
        logic [7:0]                     address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } host_bus_req_t;

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP, A_STROBE, A_HOLD, A_WAIT,
        D_SETUP, D_STROBE, D_HOLD, D_WAIT,
        R_SETUP, R_STROBE, R_HOLD
    } host_bus_state_t;

    // Chip register select: A1 picks the bank, A0 picks address (0) or data (1) port.
    function automatic logic [1:0] bus_reg_sel(input logic bank, input logic data_port);
        return {bank, data_port};
    endfunction

endpackage

// File: rtl/host_bus_master.sv
// Sequences register writes (address then data cycle) and status reads on a
// slow 8-bit chip bus with programmable setup/strobe/hold/recovery timing.
module host_bus_master
    import opl3_pkg::*;
#(
    parameter int SETUP_CYCLES     = 2,
    parameter int STROBE_CYCLES    = 4,
    parameter int HOLD_CYCLES      = 2,
    parameter int ADDR_WAIT_CYCLES = 40,
    parameter int DATA_WAIT_CYCLES = 300
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  host_bus_req_t                  req,
    output logic                           cs_n,
    output logic                           wr_n,
    output logic                           rd_n,
    output logic [1:0]                     address,
    output logic [REG_FILE_DATA_WIDTH-1:0] dout,
    input  logic [REG_FILE_DATA_WIDTH-1:0] din,
    output logic                           rd_valid,
    output logic [REG_FILE_DATA_WIDTH-1:0] rd_data,
    output logic                           busy
);

    localparam int MAX_AB  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_ABC = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
    localparam int MAX_W   = (ADDR_WAIT_CYCLES > DATA_WAIT_CYCLES) ? ADDR_WAIT_CYCLES : DATA_WAIT_CYCLES;
    localparam int MAX_CYCLES = (MAX_ABC > MAX_W) ? MAX_ABC : MAX_W;
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        ADDR_WAIT_CYCLES < 1 || DATA_WAIT_CYCLES < 1) begin : g_bad_params
        $error("host_bus_master: every timing parameter must be at least 1");
    end

    host_bus_state_t                state;
    logic [CNT_W-1:0]               cnt;
    logic                           started;
    logic                           bank_q;
    logic [7:0]                     addr_q;
    logic [REG_FILE_DATA_WIDTH-1:0] data_q;

    // Counter value loaded on entry: the state lasts (value + 1) cycles.
    function automatic logic [CNT_W-1:0] hold_for(input host_bus_state_t s);
        case (s)
            A_SETUP, D_SETUP, R_SETUP:    hold_for = CNT_W'(SETUP_CYCLES - 1);
            A_STROBE, D_STROBE, R_STROBE: hold_for = CNT_W'(STROBE_CYCLES - 1);
            A_HOLD, D_HOLD, R_HOLD:       hold_for = CNT_W'(HOLD_CYCLES - 1);
            A_WAIT:                       hold_for = CNT_W'(ADDR_WAIT_CYCLES - 1);
            D_WAIT:                       hold_for = CNT_W'(DATA_WAIT_CYCLES - 1);
            default:                      hold_for = '0;
        endcase
    endfunction

    function automatic host_bus_state_t next_state(input host_bus_state_t s);
        case (s)
            A_SETUP:  next_state = A_STROBE;
            A_STROBE: next_state = A_HOLD;
            A_HOLD:   next_state = A_WAIT;
            A_WAIT:   next_state = D_SETUP;
            D_SETUP:  next_state = D_STROBE;
            D_STROBE: next_state = D_HOLD;
            D_HOLD:   next_state = D_WAIT;
            R_SETUP:  next_state = R_STROBE;
            R_STROBE: next_state = R_HOLD;
            default:  next_state = IDLE;
        endcase
    endfunction

    // started keeps req_ready low until the first edge after reset release.
    assign req_ready = started && (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            started  <= 1'b0;
            bank_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cs_n     <= 1'b1;
            wr_n     <= 1'b1;
            rd_n     <= 1'b1;
            address  <= '0;
            dout     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            started  <= 1'b1;
            rd_valid <= 1'b0;

            // Bus pins follow the current state one cycle late.
            cs_n <= !(state inside {A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD,
                                    R_SETUP, R_STROBE, R_HOLD});
            wr_n <= !(state inside {A_STROBE, D_STROBE});
            rd_n <= (state != R_STROBE);
            case (state)
                A_SETUP, A_STROBE, A_HOLD: begin
                    address <= bus_reg_sel(bank_q, 1'b0);
                    dout    <= addr_q;
                end
                D_SETUP, D_STROBE, D_HOLD: begin
                    address <= bus_reg_sel(bank_q, 1'b1);
                    dout    <= data_q;
                end
                R_SETUP, R_STROBE, R_HOLD: address <= 2'b00;
                default: ;
            endcase

            if (state == IDLE) begin
                if (req_valid && req_ready) begin
                    bank_q <= req.bank_num;
                    addr_q <= req.address;
                    data_q <= req.data;
                    state  <= (req.op == WRITE) ? A_SETUP : R_SETUP;
                    cnt    <= hold_for((req.op == WRITE) ? A_SETUP : R_SETUP);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                state <= next_state(state);
                cnt   <= hold_for(next_state(state));
            end

            if (state == R_STROBE && cnt == '0) begin
                rd_data  <= din;
                rd_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/host_bus_master.md
HOST_BUS_MASTER -- requirements
Module: host_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, meaning cycles of address/data setup before the strobe goes low.
REQ-002 SHALL have parameter STROBE_CYCLES, default 4, meaning cycles wr_n or rd_n is held low.
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, meaning cycles address/data are held after the strobe goes high.
REQ-004 SHALL have parameter ADDR_WAIT_CYCLES, default 40, meaning idle-bus recovery after an address write.
REQ-005 SHALL have parameter DATA_WAIT_CYCLES, default 300, meaning idle-bus recovery after a data write.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-009 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-010 SHALL have port req, input, host_bus_req_t: fields op (WRITE/READ), bank_num, address[7:0], data[7:0].
REQ-011 SHALL have port cs_n, output, 1 bit: bus chip select.
REQ-012 SHALL have port wr_n, output, 1 bit: bus write strobe.
REQ-013 SHALL have port rd_n, output, 1 bit: bus read strobe.
REQ-014 SHALL have port address, output, 2 bits: bus A1:A0.
REQ-015 SHALL have port dout, output, REG_FILE_DATA_WIDTH: write data to the chip.
REQ-016 SHALL have port din, input, REG_FILE_DATA_WIDTH: read data from the chip.
REQ-017 SHALL have port rd_valid, output, 1 bit: one-cycle pulse qualifying rd_data.
REQ-018 SHALL have port rd_data, output, REG_FILE_DATA_WIDTH: captured status byte.
REQ-019 SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-020 SHALL drive req_ready = (state == IDLE); a request is accepted on any cycle with req_valid && req_ready, and the req fields are registered internally.
REQ-021 SHALL implement the FSM states IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT, D_SETUP, D_STROBE, D_HOLD, D_WAIT, R_SETUP, R_STROBE, R_HOLD.
REQ-022 SHALL hold each timed state for exactly its parameter value in cycles, counted by one down-counter reloaded on state entry; every parameter SHALL be at least 1, checked by an elaboration-time assertion.
REQ-023 SHALL sequence a WRITE as IDLE -> A_SETUP -> A_STROBE -> A_HOLD -> A_WAIT -> D_SETUP -> D_STROBE -> D_HOLD -> D_WAIT -> IDLE.
REQ-024 SHALL sequence a READ as IDLE -> R_SETUP -> R_STROBE -> R_HOLD -> IDLE.
REQ-025 SHALL, in A_*, drive address = {bank_num, 0} and dout = req address; in D_*, drive address = {bank_num, 1} and dout = req data; in R_*, drive address = 2'b00.
REQ-026 SHALL drive cs_n low in every SETUP, STROBE and HOLD state, and high in IDLE and in both WAIT states.
REQ-027 SHALL drive wr_n low only in A_STROBE and D_STROBE, and rd_n low only in R_STROBE; wr_n and rd_n SHALL never be low together.
REQ-028 SHALL register all bus outputs, so the bus changes one cycle after each state change.
REQ-029 SHALL capture din into rd_data on the final R_STROBE cycle and pulse rd_valid for exactly one cycle, concurrent with the first R_HOLD cycle.
REQ-030 SHALL keep rd_data unchanged until the next read completes.
REQ-031 SHALL ignore req_valid in any non-IDLE state; no queuing.
REQ-032 SHALL accept a new request on the cycle after returning to IDLE, which is the back-to-back minimum.
REQ-033 SHALL hold address and dout at their last values in WAIT states and in IDLE.

Reset
REQ-034 SHALL, on reset assertion, immediately and regardless of the clock, set state = IDLE, the counter = 0, cs_n = wr_n = rd_n = 1, address = 0, dout = 0, rd_valid = 0, rd_data = 0, and busy = 0.
REQ-035 SHALL abandon any in-flight transaction on reset, with no completion pulse.
REQ-036 SHALL deassert req_ready while reset is asserted, and assert it on the first clock edge after release.

Structure
REQ-037 SHALL place host_bus_req_t and the host_bus_op_t enum (WRITE, READ) in opl3_pkg, reusing REG_FILE_DATA_WIDTH.
REQ-038 SHALL be a single module with no sub-module: one FSM plus one down-counter, the counter width being $clog2 of the largest parameter + 1.

Verification
REQ-039 SHALL verify: WRITE bank 0, addr 0x02, data 0xFF with default parameters -> address 0 with dout 0x02, wr_n low 4 cycles, 40 idle cycles, then address 1 with dout 0xFF, wr_n low 4 cycles; busy high for 356 cycles.
REQ-040 SHALL verify: WRITE bank 1, addr 0x05, data 0x01 -> address 2'b10 and then 2'b11 on the bus.
REQ-041 SHALL verify: READ with din = 0xC0 during the strobe -> rd_n low 4 cycles, rd_valid pulses once, rd_data = 0xC0, wr_n stays high.
REQ-042 SHALL verify: req_valid held high across a WRITE followed by a READ -> req_ready low throughout the WRITE, the READ accepted on the first IDLE cycle, no request lost or duplicated.
REQ-043 SHALL verify: reset asserted mid A_STROBE -> cs_n and wr_n go high without a clock edge, no rd_valid pulse, a fresh request is accepted after release.
REQ-044 SHALL verify: all parameters set to 1 -> a WRITE takes 8 cycles of busy and the strobe sequencing of REQ-026/027 holds.
